// File: rtl/data_memory_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_sync_pkg
// Brief   : Shared types, size encodings and helpers for the banked data memory.
// Revision: 1.0 - initial release
// ============================================================================
package data_memory_sync_pkg;

    localparam int WIDTH = 32;
    localparam int BYTE  = 8;

    localparam logic [1:0] SIZE_BYTE      = 2'd0;
    localparam logic [1:0] SIZE_HALF_WORD = 2'd1;
    localparam logic [1:0] SIZE_WORD      = 2'd2;

    typedef struct packed {
        logic             load;
        logic             store;
        logic [1:0]       size;
        logic             sign_extend;
        logic [WIDTH-1:0] address;
        logic [WIDTH-1:0] write_data;
    } mem_req_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // Bit k set means big-endian lane k (bits [31-8k -: 8]) is touched.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SIZE_BYTE:      m = 4'b0001 << off;
            SIZE_HALF_WORD: m = 4'b0011 << off;
            SIZE_WORD:      m = 4'b1111;
            default:        m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_sync_if.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_sync_if
// Brief   : Request/response valid-ready bundle between MEM stage and data memory.
// Revision: 1.0 - initial release
// ============================================================================
interface data_memory_sync_if;
    import data_memory_sync_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_load;
    logic             req_store;
    logic [1:0]       req_size;
    logic             req_sign_extend;
    logic [WIDTH-1:0] req_address;
    logic [WIDTH-1:0] req_write_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_read_data;
    logic             rsp_fault;

    modport master (
        output req_valid, req_load, req_store, req_size, req_sign_extend,
               req_address, req_write_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_read_data, rsp_fault
    );

    modport slave (
        input  req_valid, req_load, req_store, req_size, req_sign_extend,
               req_address, req_write_data, rsp_ready,
        output req_ready, rsp_valid, rsp_read_data, rsp_fault
    );

endinterface
`default_nettype wire

// File: rtl/data_memory_sync_bank.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_bank
// Brief   : One 8-bit byte lane: single write port with enable, registered read.
// Revision: 1.0 - initial release
// ============================================================================
module data_memory_bank #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] index_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [2**IDX_W];
    logic [7:0] rdata_q;

    // Contents are deliberately left unreset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[index_i] <= wdata_i;
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[index_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_memory_sync.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_sync
// Brief   : Byte-lane-banked big-endian data memory with valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module data_memory_sync
    import data_memory_sync_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter bit CHECK_ALIGN = 1'b1,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    data_memory_sync_if.slave bus
);

    localparam int IDX_W = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;

    mem_req_t         req;
    state_t           state_q, state_d;
    logic             req_ready, rsp_valid, accept, is_op;
    logic             range_flt, align_flt, illegal, fault;
    logic [1:0]       off;
    logic [3:0]       lane_en;
    logic [31:0]      wr_steer, raw, rdata;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [IDX_W-1:0] index;
    logic [7:0]       rd_lane [4];
    logic             fault_q, fault_d, load_q, load_d, sext_q, sext_d;
    logic [1:0]       size_q, size_d, off_q, off_d;

    assign req = '{load: bus.req_load, store: bus.req_store, size: bus.req_size,
                   sign_extend: bus.req_sign_extend, address: bus.req_address,
                   write_data: bus.req_write_data};

    generate
        if (CHECK_RANGE && ADDR_WIDTH < WIDTH) begin : g_range
            assign range_flt = |req.address[WIDTH-1:ADDR_WIDTH];
        end else begin : g_no_range
            assign range_flt = 1'b0;
        end
        if (ADDR_WIDTH > 2) begin : g_index
            assign index = req.address[ADDR_WIDTH-1:2];
        end else begin : g_index_single
            assign index = '0;
        end
    endgenerate

    assign rsp_valid = (state_q == ST_RESP);
    assign req_ready = !rsp_valid || bus.rsp_ready;
    assign accept    = bus.req_valid && req_ready;
    assign is_op     = req.load || req.store;

    always_comb begin
        off       = req.address[1:0];
        align_flt = 1'b0;
        illegal   = (req.load && req.store) || (req.size == 2'd3);
        case (req.size)
            SIZE_HALF_WORD: begin
                if (CHECK_ALIGN) align_flt = off[0];
                else             off[0]    = 1'b0;
            end
            SIZE_WORD: begin
                if (CHECK_ALIGN) align_flt = |off;
                else             off       = 2'b00;
            end
            default: ;
        endcase
        fault   = illegal || range_flt || align_flt;
        lane_en = lane_mask(req.size, off);
        // Replicating right-justified data lets every lane pick its byte statically.
        case (req.size)
            SIZE_BYTE:      wr_steer = {4{req.write_data[7:0]}};
            SIZE_HALF_WORD: wr_steer = {2{req.write_data[15:0]}};
            default:        wr_steer = req.write_data;
        endcase
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            data_memory_bank #(.IDX_W(IDX_W)) u_bank (
                .clk     (clk),
                .we_i    (accept && req.store && !fault && lane_en[k] && !rst),
                .rd_en_i (accept && req.load && !fault && !rst),
                .index_i (index),
                .wdata_i (wr_steer[31-8*k -: 8]),
                .rdata_o (rd_lane[k])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        load_d  = load_q;
        sext_d  = sext_q;
        size_d  = size_q;
        off_d   = off_q;
        if (accept && is_op) begin
            state_d = ST_RESP;
            fault_d = fault;
            load_d  = req.load && !fault;
            sext_d  = req.sign_extend;
            size_d  = req.size;
            off_d   = off;
        end else if (rsp_valid && bus.rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
            load_q  <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            load_q  <= load_d;
            sext_q  <= sext_d;
            size_q  <= size_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        raw      = {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]};
        byte_sel = raw[{~off_q, 3'b000} +: BYTE];
        half_sel = off_q[1] ? raw[15:0] : raw[31:16];
        rdata    = '0;
        if (load_q) begin
            case (size_q)
                SIZE_BYTE:      rdata = {{24{sext_q & byte_sel[7]}}, byte_sel};
                SIZE_HALF_WORD: rdata = {{16{sext_q & half_sel[15]}}, half_sel};
                default:        rdata = raw;
            endcase
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_read_data = rdata;
    assign bus.rsp_fault     = fault_q;

endmodule
`default_nettype wire
